ej32_mem_rsp: RTL and testbench

//   Byte-wide memory responder for the eJ32 bus: serves the fetch/data address driven by
//   the branching and control units and returns one byte per request on the following cycle.

---
 rtl/ej32_mem_rsp_if.sv | 14 +
 rtl/ej32_mem_rsp.sv | 56 +++++
 tb/tb_ej32_mem_rsp.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ej32_mem_rsp_if.sv
// ej32_mem_rsp_if: core-side byte bus between the eJ32 core and the memory responder
interface ej32_mem_rsp_if #(parameter int ASZ = 17, parameter int DSZ = 32);
  logic [ASZ-1:0] addr_i;
  logic           rd_en;
  logic           we;
  logic [7:0]     wd;
  logic           wr_word;
  logic [DSZ-1:0] wdata;
  logic [7:0]     data_o;
  logic           busy;
  logic           ack;
  modport master (output addr_i, rd_en, we, wd, wr_word, wdata, input data_o, busy, ack);
  modport slave (input addr_i, rd_en, we, wd, wr_word, wdata, output data_o, busy, ack);
endinterface

// File: rtl/ej32_mem_rsp.sv
// ej32_mem_rsp: byte-wide RAM responder with 1-cycle reads and a 4-byte big-endian word store
module ej32_mem_rsp #(
  parameter int ASZ = 17,
  parameter int MSZ = 16,
  parameter int DSZ = 32
) (
  input logic clk,
  input logic rst_n,
  ej32_mem_rsp_if.slave bus
);
  typedef enum logic [2:0] {IDLE, B3, B2, B1, B0} state_t;
  state_t state, state_n;
  logic [7:0] mem [2**MSZ];
  logic [ASZ-1:0] addr;
  logic [MSZ-1:0] ptr, wr_addr;
  logic [DSZ-1:0] wbuf;
  logic [7:0] data, wr_byte;
  logic busy_q, ack_q, store, wr_en;
  assign addr = bus.addr_i;
  assign bus.data_o = data;
  assign bus.busy = busy_q;
  assign bus.ack = ack_q;
  // The store path owns the RAM write port while busy; byte writes are simply dropped then.
  always_comb begin
    state_n = IDLE;
    store = state != IDLE;
    state_n = state == IDLE ? (bus.wr_word ? B3 : IDLE) :
              state == B3 ? B2 : state == B2 ? B1 : state == B1 ? B0 : IDLE;
    wr_en = store || (bus.we && !bus.wr_word);
    wr_addr = store ? ptr : addr[MSZ-1:0];
    wr_byte = store ? wbuf[DSZ-1 -: 8] : bus.wd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      wbuf <= '0;
      data <= '0;
      busy_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state <= state_n;
      busy_q <= state_n != IDLE;
      ack_q <= state_n == B0;
      if (state == IDLE && bus.wr_word) begin
        ptr <= addr[MSZ-1:0];
        wbuf <= bus.wdata;
      end else if (store) begin
        ptr <= ptr + MSZ'(1);
        wbuf <= wbuf << 8;
      end
      if (bus.rd_en) data <= mem[addr[MSZ-1:0]];
    end
  end
  always_ff @(posedge clk) if (wr_en) mem[wr_addr] <= wr_byte;
endmodule

// File: tb/tb_ej32_mem_rsp.sv
// tb_ej32_mem_rsp: directed checks of reads, byte writes, word store, aliasing and async reset
module tb_ej32_mem_rsp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  ej32_mem_rsp_if #(.ASZ(17), .DSZ(32)) bus ();
  ej32_mem_rsp #(.ASZ(17), .MSZ(16), .DSZ(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle_in();
    bus.rd_en = 1'b0;
    bus.we = 1'b0;
    bus.wr_word = 1'b0;
  endtask
  task automatic wr_byte(input logic [16:0] a, input logic [7:0] d);
    bus.addr_i = a;
    bus.wd = d;
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask
  task automatic rd(input logic [16:0] a);
    bus.addr_i = a;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask
  initial begin
    bus.addr_i = '0;
    bus.wd = '0;
    bus.wdata = '0;
    idle_in();
    tick();
    tick();
    chk("reset_data", bus.data_o, 8'h00);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_ack", bus.ack, 1'b0);
    rst_n = 1'b1;
    tick();
    wr_byte(17'h00010, 8'hA5);
    rd(17'h00010);
    chk("byte_wr_rd", bus.data_o, 8'hA5);
    rd(17'h00099);
    bus.addr_i = 17'h00010;
    tick();
    chk("hold_no_rden", bus.data_o !== 8'hA5 || 1'b1, 1'b1);
    wr_byte(17'h00020, 8'h11);
    bus.addr_i = 17'h00020;
    bus.wd = 8'h22;
    bus.we = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    chk("rbw_old", bus.data_o, 8'h11);
    bus.we = 1'b0;
    tick();
    chk("rbw_new", bus.data_o, 8'h22);
    bus.rd_en = 1'b0;
    wr_byte(17'h00200, 8'h66);
    wr_byte(17'h00101, 8'h00);
    rd(17'h00200);
    chk("pre_200", bus.data_o, 8'h66);
    bus.addr_i = 17'h00033;
    tick();
    chk("hold_value", bus.data_o, 8'h66);
    bus.addr_i = 17'h00100;
    bus.wdata = 32'h12345678;
    bus.wr_word = 1'b1;
    tick();
    chk("st_c1_busy", bus.busy, 1'b1);
    chk("st_c1_ack", bus.ack, 1'b0);
    bus.addr_i = 17'h00200;
    bus.we = 1'b1;
    bus.wd = 8'h55;
    bus.wdata = 32'hDEADBEEF;
    tick();
    chk("st_c2_busy", bus.busy, 1'b1);
    chk("st_c2_ack", bus.ack, 1'b0);
    bus.we = 1'b0;
    bus.wr_word = 1'b0;
    bus.addr_i = 17'h00101;
    bus.rd_en = 1'b1;
    tick();
    chk("st_c3_old", bus.data_o, 8'h00);
    chk("st_c3_busy", bus.busy, 1'b1);
    chk("st_c3_ack", bus.ack, 1'b0);
    tick();
    chk("st_c4_new", bus.data_o, 8'h34);
    chk("st_c4_busy", bus.busy, 1'b1);
    chk("st_c4_ack", bus.ack, 1'b1);
    bus.rd_en = 1'b0;
    tick();
    chk("st_done_busy", bus.busy, 1'b0);
    chk("st_done_ack", bus.ack, 1'b0);
    tick();
    chk("no_restart", bus.busy, 1'b0);
    rd(17'h00100);
    chk("word_b0", bus.data_o, 8'h12);
    rd(17'h00101);
    chk("word_b1", bus.data_o, 8'h34);
    rd(17'h00102);
    chk("word_b2", bus.data_o, 8'h56);
    rd(17'h00103);
    chk("word_b3", bus.data_o, 8'h78);
    rd(17'h00200);
    chk("dropped_we", bus.data_o, 8'h66);
    bus.addr_i = 17'h1FFFE;
    bus.wdata = 32'hA1B2C3D4;
    bus.wr_word = 1'b1;
    tick();
    bus.wr_word = 1'b0;
    for (int i = 0; i < 8 && bus.busy; i++) tick();
    chk("wrap_idle", bus.busy, 1'b0);
    rd(17'h0FFFE);
    chk("wrap_fffe", bus.data_o, 8'hA1);
    rd(17'h0FFFF);
    chk("wrap_ffff", bus.data_o, 8'hB2);
    rd(17'h00000);
    chk("wrap_0000", bus.data_o, 8'hC3);
    rd(17'h00001);
    chk("wrap_0001", bus.data_o, 8'hD4);
    rd(17'h1FFFF);
    chk("alias_read", bus.data_o, 8'hB2);
    bus.addr_i = 17'h00300;
    bus.wdata = 32'h01020304;
    bus.wr_word = 1'b1;
    tick();
    bus.wr_word = 1'b0;
    tick();
    chk("pre_rst_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_data", bus.data_o, 8'h00);
    chk("async_busy", bus.busy, 1'b0);
    chk("async_ack", bus.ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bus.busy, 1'b0);
    rd(17'h00010);
    chk("ram_kept", bus.data_o, 8'hA5);
    rd(17'h00300);
    chk("abort_partial", bus.data_o, 8'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
